axi_lite_reg_bank: RTL and testbench
====================================

AXI_LITE_REG_BANK -- requirements
Module: axi_lite_reg_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, data bus width; legal values 32 or 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3, word-index address width.
REQ-003 SHALL have parameter NUM_REGS, default 8, register count; 1 <= NUM_REGS <= 2**ADDR_WIDTH.
REQ-004 SHALL have parameter RO_MASK, default 8'h01, width NUM_REGS; bit i=1 makes register i read-only, sourced from hw_in.
REQ-005 SHALL have a single clock and an asynchronous active-low reset, with ports named clk and rst.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 awvalid, awready, awaddr  in/out/in  1/1/ADDR_WIDTH  write address channel.
REQ-009 wvalid, wready, wdata, wstrb  in/out/in/in  1/1/DATA_WIDTH/DATA_WIDTH/8  write data channel.
REQ-010 bvalid, bready, bresp  out/in/out  1/1/2  write response channel.
REQ-011 arvalid, arready, araddr  in/out/in  1/1/ADDR_WIDTH  read address channel.
REQ-012 rvalid, rready, rdata, rresp  out/in/out/out  1/1/DATA_WIDTH/2  read data channel.
REQ-013 hw_in  in  NUM_REGS*DATA_WIDTH  read-only register sources, slice i at [i*DATA_WIDTH +: DATA_WIDTH].
REQ-014 reg_out  out  NUM_REGS*DATA_WIDTH  current read-write register contents; RO slices drive 0.
REQ-015 wr_pulse  out  NUM_REGS  one-cycle commit strobe per register.

Function
REQ-016 Handshake: a transfer SHALL occur on a rising edge where valid and ready are both 1; valid/payload are held by the source until transfer.
REQ-017 Write FSM states SHALL be W_IDLE and W_RESP.
REQ-018 In W_IDLE: awready=1 until the AW beat is captured and wready=1 until the W beat is captured; AW and W are accepted in either order or in the same cycle.
REQ-019 In W_IDLE: awready/wready SHALL drop to 0 on the cycle after their own beat is captured.
REQ-020 On the edge where the second of AW/W is captured, the write SHALL commit and the FSM SHALL enter W_RESP.
REQ-021 Commit, legal target (index < NUM_REGS and RO_MASK bit 0): for each byte k with wstrb[k]=1, that byte of the register is updated; wr_pulse[index]=1 for exactly the next cycle; bresp=2'b00.
REQ-022 Commit, illegal target (index >= NUM_REGS or RO register): no state change; no wr_pulse; bresp=2'b10 (SLVERR).
REQ-023 In W_RESP: bvalid=1, awready=0, wready=0; when bready=1, the FSM SHALL return to W_IDLE and bvalid=0 from the next cycle.
REQ-024 Write throughput SHALL be one write per 2 cycles at best (capture plus response cycle).
REQ-025 Read FSM states SHALL be R_IDLE and R_DATA.
REQ-026 In R_IDLE: arready=1; on an AR transfer, rdata SHALL be registered from the addressed source (hw_in slice if RO, else register) and the FSM SHALL enter R_DATA.
REQ-027 Read latency SHALL be 1 cycle: rvalid=1 in the cycle following the AR transfer.
REQ-028 Read, out-of-range index: rdata=0 and rresp=2'b10; otherwise rresp=2'b00.
REQ-029 In R_DATA: arready=0 and rdata/rresp are held stable; rready=1 SHALL return the FSM to R_IDLE.
REQ-030 Read and write FSMs SHALL be independent.
REQ-031 A read captured on the same edge as a write commit to the same register SHALL return the pre-write value.
REQ-032 wstrb=0 to a legal RW target SHALL still yield OKAY and a wr_pulse, with no data change.

Reset
REQ-033 While rst=0, asynchronously: all RW registers=0, FSMs in W_IDLE/R_IDLE, bvalid=rvalid=0, bresp=rresp=0, rdata=0, wr_pulse=0, and any captured AW/W beat is discarded.
REQ-034 Out of reset: awready=wready=arready=1 from the first clk edge after rst rises.
REQ-035 Reset asserted mid-transaction SHALL abort the transaction; no response is later issued for it.

Verification
REQ-036 AW idx 2 and W 0xDEADBEEF with wstrb 4'hF in the same cycle -> next cycle bvalid=1, bresp=00, wr_pulse[2]=1; then a read of idx 2 returns 0xDEADBEEF.
REQ-037 W beat 3 cycles before AW (idx 3, 0x11223344, wstrb 4'b0101), register previously 0xFFFFFFFF -> reg 3 = 0xFF22FF44, bresp=00.
REQ-038 Write to idx 0 (RO) or idx 9 with NUM_REGS=8, ADDR_WIDTH=4 -> bresp=10, no wr_pulse, registers unchanged; read of idx 9 -> rdata=0, rresp=10.
REQ-039 hw_in slice 0 = 0xCAFE0001, AR idx 0 with rready held 0 for 4 cycles -> rvalid stays 1, rdata stays 0xCAFE0001, arready=0 until rready=1.
REQ-040 Read and write to idx 5 (old value 0xA, new 0xB) on the same edge -> rdata=0xA, then reg 5 = 0xB; bready held 0 for 3 cycles keeps bvalid=1 and awready=0.
REQ-041 rst pulsed low during W_RESP -> bvalid=0 immediately, all RW regs=0, no response after release.

Source files
------------

// File: rtl/axi_lite_reg_bank.sv
// AXI4-Lite register bank: NUM_REGS words, RW registers stored locally, RO words
// read straight from hw_in. Independent write (W_IDLE/W_RESP) and read (R_IDLE/R_DATA) FSMs.
module axi_lite_reg_bank #(
    parameter int                   DATA_WIDTH = 32,
    parameter int                   ADDR_WIDTH = 3,
    parameter int                   NUM_REGS   = 8,
    parameter logic [NUM_REGS-1:0]  RO_MASK    = 8'h01
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           awvalid,
    output logic                           awready,
    input  logic [ADDR_WIDTH-1:0]          awaddr,
    input  logic                           wvalid,
    output logic                           wready,
    input  logic [DATA_WIDTH-1:0]          wdata,
    input  logic [DATA_WIDTH/8-1:0]        wstrb,
    output logic                           bvalid,
    input  logic                           bready,
    output logic [1:0]                     bresp,
    input  logic                           arvalid,
    output logic                           arready,
    input  logic [ADDR_WIDTH-1:0]          araddr,
    output logic                           rvalid,
    input  logic                           rready,
    output logic [DATA_WIDTH-1:0]          rdata,
    output logic [1:0]                     rresp,
    input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]            wr_pulse
);
    localparam int STRB_W = DATA_WIDTH / 8;

    typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
    typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;

    w_state_t                r_wstate;
    r_state_t                r_rstate;
    logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];
    logic                    r_awready;
    logic                    r_wready;
    logic                    r_arready;
    logic                    r_aw_got;
    logic                    r_w_got;
    logic [ADDR_WIDTH-1:0]   r_awaddr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [STRB_W-1:0]       r_wstrb;
    logic                    r_bvalid;
    logic [1:0]              r_bresp;
    logic                    r_rvalid;
    logic [DATA_WIDTH-1:0]   r_rdata;
    logic [1:0]              r_rresp;
    logic [NUM_REGS-1:0]     r_wr_pulse;

    logic                    w_aw_fire;
    logic                    w_w_fire;
    logic                    w_ar_fire;
    logic                    w_have_aw;
    logic                    w_have_w;
    logic                    w_commit;
    logic [ADDR_WIDTH-1:0]   w_cmt_addr;
    logic [DATA_WIDTH-1:0]   w_cmt_data;
    logic [STRB_W-1:0]       w_cmt_strb;
    logic [NUM_REGS-1:0]     w_wr_sel;
    logic                    w_wr_legal;
    logic [DATA_WIDTH-1:0]   w_rd_data;
    logic                    w_rd_hit;

    function automatic logic [DATA_WIDTH-1:0] f_merge(
        input logic [DATA_WIDTH-1:0] old_v,
        input logic [DATA_WIDTH-1:0] new_v,
        input logic [STRB_W-1:0]     strb
    );
        logic [DATA_WIDTH-1:0] res;
        res = old_v;
        for (int k = 0; k < STRB_W; k++) begin
            res[k*8 +: 8] = strb[k] ? new_v[k*8 +: 8] : old_v[k*8 +: 8];
        end
        return res;
    endfunction

    // A beat arriving on the commit edge is used directly; an earlier one comes from its holding register.
    assign w_aw_fire  = awvalid & r_awready;
    assign w_w_fire   = wvalid & r_wready;
    assign w_ar_fire  = arvalid & r_arready;
    assign w_have_aw  = r_aw_got | w_aw_fire;
    assign w_have_w   = r_w_got | w_w_fire;
    assign w_commit   = (r_wstate == W_IDLE) & w_have_aw & w_have_w;
    assign w_cmt_addr = r_aw_got ? r_awaddr : awaddr;
    assign w_cmt_data = r_w_got ? r_wdata : wdata;
    assign w_cmt_strb = r_w_got ? r_wstrb : wstrb;

    // Write target decode: one-hot select of a writable register, empty for RO or out-of-range.
    always_comb begin
        w_wr_sel = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            w_wr_sel[i] = (w_cmt_addr == ADDR_WIDTH'(i)) & ~RO_MASK[i];
        end
        w_wr_legal = |w_wr_sel;
    end

    // Read source mux: RO words come from hw_in, out-of-range reads yield zero.
    always_comb begin
        w_rd_data = {DATA_WIDTH{1'b0}};
        w_rd_hit  = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_rd_hit  = w_rd_hit | (araddr == ADDR_WIDTH'(i));
            w_rd_data = w_rd_data | ({DATA_WIDTH{araddr == ADDR_WIDTH'(i)}} &
                        (RO_MASK[i] ? hw_in[i*DATA_WIDTH +: DATA_WIDTH] : r_regs[i]));
        end
    end

    // Write FSM: beat capture, register commit, commit strobe and write response.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wstate   <= W_IDLE;
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_got   <= 1'b0;
            r_w_got    <= 1'b0;
            r_awaddr   <= {ADDR_WIDTH{1'b0}};
            r_wdata    <= {DATA_WIDTH{1'b0}};
            r_wstrb    <= {STRB_W{1'b0}};
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= {DATA_WIDTH{1'b0}};
            end
        end else begin
            r_wr_pulse <= w_commit ? w_wr_sel : {NUM_REGS{1'b0}};
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && w_wr_sel[i]) begin
                    r_regs[i] <= f_merge(r_regs[i], w_cmt_data, w_cmt_strb);
                end
            end
            case (r_wstate)
                W_IDLE: begin
                    if (w_commit) begin
                        r_wstate  <= W_RESP;
                        r_bvalid  <= 1'b1;
                        r_bresp   <= w_wr_legal ? 2'b00 : 2'b10;
                        r_awready <= 1'b0;
                        r_wready  <= 1'b0;
                        r_aw_got  <= 1'b0;
                        r_w_got   <= 1'b0;
                    end else begin
                        r_awready <= ~w_have_aw;
                        r_wready  <= ~w_have_w;
                        if (w_aw_fire) begin
                            r_aw_got <= 1'b1;
                            r_awaddr <= awaddr;
                        end
                        if (w_w_fire) begin
                            r_w_got <= 1'b1;
                            r_wdata <= wdata;
                            r_wstrb <= wstrb;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        r_wstate  <= W_IDLE;
                        r_bvalid  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                    end
                end
                default: begin
                    r_wstate  <= W_IDLE;
                    r_bvalid  <= 1'b0;
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                end
            endcase
        end
    end

    // Read FSM: registers rdata/rresp on the AR beat and holds them until rready.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= {DATA_WIDTH{1'b0}};
            r_rresp   <= 2'b00;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_fire) begin
                        r_rstate  <= R_DATA;
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_data;
                        r_rresp   <= w_rd_hit ? 2'b00 : 2'b10;
                    end else begin
                        r_arready <= 1'b1;
                    end
                end
                R_DATA: begin
                    if (rready) begin
                        r_rstate  <= R_IDLE;
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                    end
                end
                default: begin
                    r_rstate  <= R_IDLE;
                    r_rvalid  <= 1'b0;
                    r_arready <= 1'b0;
                end
            endcase
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = RO_MASK[g] ? {DATA_WIDTH{1'b0}} : r_regs[g];
    end

    assign awready  = r_awready;
    assign wready   = r_wready;
    assign arready  = r_arready;
    assign bvalid   = r_bvalid;
    assign bresp    = r_bresp;
    assign rvalid   = r_rvalid;
    assign rdata    = r_rdata;
    assign rresp    = r_rresp;
    assign wr_pulse = r_wr_pulse;

endmodule

// File: tb/tb_axi_lite_reg_bank.sv
// Self-checking bench for axi_lite_reg_bank: directed scenarios plus randomized
// traffic checked against an array-based model of the register file.
module tb_axi_lite_reg_bank;
    localparam int         DW   = 32;
    localparam int         AW   = 4;
    localparam int         NR   = 8;
    localparam logic [7:0] RO_M = 8'h01;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic            awready, wready, bvalid, arready, rvalid;
    logic [AW-1:0]   awaddr = 4'd0, araddr = 4'd0;
    logic [DW-1:0]   wdata = 32'd0, rdata;
    logic [3:0]      wstrb = 4'd0;
    logic [1:0]      bresp, rresp;
    logic [NR*DW-1:0] hw_in = 256'd0, reg_out;
    logic [NR-1:0]   wr_pulse;

    logic [31:0] model   [NR];
    logic [31:0] hw_vals [NR];
    int checks   = 0;
    int failures = 0;

    axi_lite_reg_bank #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR), .RO_MASK(RO_M)) dut (
        .clk(clk), .rst(rst),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .hw_in(hw_in), .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] model_vec();
        logic [255:0] v;
        for (int i = 0; i < NR; i++) v[i*32 +: 32] = RO_M[i] ? 32'd0 : model[i];
        return v;
    endfunction

    task automatic set_hw(input int i, input logic [31:0] v);
        hw_vals[i] = v;
        hw_in[i*32 +: 32] = v;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // lead > 0: W beat leads AW by lead cycles; lead < 0: AW leads W; 0: together.
    task automatic do_write(input logic [3:0] idx, input logic [31:0] data, input logic [3:0] strb, input int lead);
        int t;
        bit aw_done, w_done, fa, fw, legal;
        int ii;
        t = 0; aw_done = 1'b0; w_done = 1'b0;
        awaddr = idx; wdata = data; wstrb = strb;
        if (lead >= 0) wvalid = 1'b1;
        if (lead <= 0) awvalid = 1'b1;
        while (!(aw_done && w_done) && t < 40) begin
            fa = awvalid && awready;
            fw = wvalid && wready;
            tick();
            t++;
            if (fa) begin awvalid = 1'b0; aw_done = 1'b1; end
            if (fw) begin wvalid = 1'b0; w_done = 1'b1; end
            if (!aw_done && !awvalid && t >= lead) awvalid = 1'b1;
            if (!w_done && !wvalid && t >= -lead) wvalid = 1'b1;
        end
        awvalid = 1'b0; wvalid = 1'b0;
        check("wr_handshake_done", {aw_done, w_done}, 2'b11);
        ii = idx;
        legal = (ii < NR) ? !RO_M[ii] : 1'b0;
        check("wr_bvalid", bvalid, 1'b1);
        check("wr_bresp", bresp, legal ? 2'b00 : 2'b10);
        check("wr_pulse", wr_pulse, legal ? (8'h01 << ii) : 8'h00);
        check("wr_ready_low", {awready, wready}, 2'b00);
        if (legal) begin
            for (int k = 0; k < 4; k++) if (strb[k]) model[ii][k*8 +: 8] = data[k*8 +: 8];
        end
        check("wr_reg_out", reg_out, model_vec());
    endtask

    task automatic do_bresp(input int hold);
        bready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            tick();
            check("b_hold_bvalid", bvalid, 1'b1);
            check("b_hold_awready", awready, 1'b0);
            check("b_hold_pulse", wr_pulse, 8'h00);
        end
        bready = 1'b1;
        tick();
        bready = 1'b0;
        check("b_done_bvalid", bvalid, 1'b0);
        check("b_done_pulse", wr_pulse, 8'h00);
        check("b_done_ready", {awready, wready}, 2'b11);
    endtask

    task automatic do_read(input logic [3:0] idx, input int stall);
        int t, ii;
        bit done, fa;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        ii = idx;
        exp_d = (ii < NR) ? (RO_M[ii] ? hw_vals[ii] : model[ii]) : 32'd0;
        exp_r = (ii < NR) ? 2'b00 : 2'b10;
        araddr = idx; arvalid = 1'b1; t = 0; done = 1'b0;
        while (!done && t < 40) begin
            fa = arvalid && arready;
            tick();
            t++;
            if (fa) done = 1'b1;
        end
        arvalid = 1'b0;
        check("rd_handshake_done", done, 1'b1);
        check("rd_rvalid", rvalid, 1'b1);
        check("rd_rdata", rdata, exp_d);
        check("rd_rresp", rresp, exp_r);
        check("rd_arready_low", arready, 1'b0);
        for (int s = 0; s < stall; s++) begin
            tick();
            check("rd_stall_rvalid", rvalid, 1'b1);
            check("rd_stall_rdata", rdata, exp_d);
            check("rd_stall_arready", arready, 1'b0);
        end
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rd_done_rvalid", rvalid, 1'b0);
        check("rd_done_arready", arready, 1'b1);
    endtask

    initial begin
        for (int i = 0; i < NR; i++) begin
            model[i] = 32'd0;
            set_hw(i, $urandom());
        end
        #2 rst = 1'b0;
        #10;
        check("rst_valids", {bvalid, rvalid}, 2'b00);
        check("rst_resps", {bresp, rresp}, 4'b0000);
        check("rst_rdata", rdata, 32'd0);
        check("rst_pulse", wr_pulse, 8'h00);
        check("rst_reg_out", reg_out, 256'd0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        tick();
        check("post_rst_ready", {awready, wready, arready}, 3'b111);

        // Same-cycle AW/W, full strobe.
        do_write(4'd2, 32'hDEADBEEF, 4'hF, 0);
        check("same_cycle_pulse2", wr_pulse, 8'h04);
        do_bresp(0);
        do_read(4'd2, 0);

        // W three cycles ahead of AW, partial strobe over all-ones.
        do_write(4'd3, 32'hFFFFFFFF, 4'hF, -1);
        do_bresp(1);
        do_write(4'd3, 32'h11223344, 4'b0101, 3);
        check("partial_strobe_reg3", reg_out[3*32 +: 32], 32'hFF22FF44);
        do_bresp(0);

        // Illegal targets: RO index 0 and out-of-range index 9.
        do_write(4'd0, 32'h12345678, 4'hF, 0);
        do_bresp(0);
        do_write(4'd9, 32'h87654321, 4'hF, -2);
        do_bresp(0);
        do_read(4'd9, 0);

        // Zero strobe to a legal register: OKAY and strobe, no data change.
        do_write(4'd6, 32'hA5A5A5A5, 4'h0, 0);
        do_bresp(0);

        // RO read with a stalled rready.
        set_hw(0, 32'hCAFE0001);
        do_read(4'd0, 4);

        // Simultaneous read and write of register 5 returns the old value.
        do_write(4'd5, 32'h0000000A, 4'hF, 0);
        do_bresp(0);
        awaddr = 4'd5; wdata = 32'h0000000B; wstrb = 4'hF; araddr = 4'd5;
        awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1;
        tick();
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        model[5] = 32'h0000000B;
        check("rw_same_rvalid", rvalid, 1'b1);
        check("rw_same_rdata_old", rdata, 32'h0000000A);
        check("rw_same_bvalid", bvalid, 1'b1);
        check("rw_same_reg5_new", reg_out[5*32 +: 32], 32'h0000000B);
        do_bresp(3);
        rready = 1'b1;
        tick();
        rready = 1'b0;
        check("rw_same_rdone", rvalid, 1'b0);

        // Randomized traffic against the model.
        for (int n = 0; n < 24; n++) begin
            set_hw($urandom_range(0, NR - 1), $urandom());
            do_write(4'($urandom_range(0, 9)), $urandom(), 4'($urandom_range(0, 15)), $urandom_range(0, 4) - 2);
            do_bresp($urandom_range(0, 2));
            do_read(4'($urandom_range(0, 9)), $urandom_range(0, 2));
        end

        // Reset during W_RESP discards the pending response and clears RW registers.
        do_write(4'd4, 32'h5A5A5A5A, 4'hF, 0);
        rst = 1'b0;
        #2;
        check("midrst_bvalid", bvalid, 1'b0);
        check("midrst_reg_out", reg_out, 256'd0);
        check("midrst_pulse", wr_pulse, 8'h00);
        for (int i = 0; i < NR; i++) model[i] = 32'd0;
        #2 rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            check("postrst_no_bvalid", bvalid, 1'b0);
        end
        check("postrst_ready", {awready, wready, arready}, 3'b111);
        do_read(4'd4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
